// File: rtl/music_pkg.sv
// Shared definitions for the music player blocks: voice count default,
// note/duration field width and the allocator state encoding.
package music_pkg;

    localparam int unsigned NUM_VOICES_DEFAULT = 3;
    localparam int unsigned NOTE_WIDTH         = 6;

    typedef enum logic {
        IDLE = 1'b0,
        LOAD = 1'b1
    } alloc_state_t;

endpackage

// File: rtl/voice_slot.sv
// Per-voice bookkeeping: busy flag, beat age, and the registered note and
// duration handed to one note_player.
module voice_slot
    import music_pkg::*;
#(
    parameter int unsigned AGE_WIDTH = 6
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  play,
    input  logic                  beat,
    input  logic                  capture,
    input  logic                  done,
    input  logic [NOTE_WIDTH-1:0] note_in,
    input  logic [NOTE_WIDTH-1:0] duration_in,
    output logic                  busy,
    output logic [AGE_WIDTH-1:0]  age,
    output logic [NOTE_WIDTH-1:0] note,
    output logic [NOTE_WIDTH-1:0] duration
);

    always_ff @(posedge clk) begin
        if (!reset) begin
            busy     <= 1'b0;
            age      <= '0;
            note     <= '0;
            duration <= '0;
        end else if (capture) begin
            // A new note wins over a same-edge done pulse for this voice.
            busy     <= 1'b1;
            age      <= '0;
            note     <= note_in;
            duration <= duration_in;
        end else begin
            if (done) begin
                busy <= 1'b0;
            end
            if (play && beat && busy && (age != '1)) begin
                age <= age + 1'b1;
            end
        end
    end

endmodule

// File: rtl/voice_allocator.sv
// Hands notes from song_reader to free note_player voices, stealing the
// oldest voice when all are busy.
module voice_allocator
    import music_pkg::*;
#(
    parameter int unsigned NUM_VOICES = NUM_VOICES_DEFAULT,
    parameter int unsigned AGE_WIDTH  = 6
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           play,
    input  logic                           beat,
    input  logic                           note_valid,
    output logic                           note_ready,
    input  logic [NOTE_WIDTH-1:0]          note_in,
    input  logic [NOTE_WIDTH-1:0]          duration_in,
    input  logic [NUM_VOICES-1:0]          note_done,
    output logic [NUM_VOICES-1:0]          load_voice,
    output logic [NOTE_WIDTH*NUM_VOICES-1:0] voice_note,
    output logic [NOTE_WIDTH*NUM_VOICES-1:0] voice_duration,
    output logic [NUM_VOICES-1:0]          busy,
    output logic [1:0]                     active_count,
    output logic                           steal
);

    alloc_state_t state, state_next;

    logic                  handshake;
    logic                  found_free;
    logic                  all_busy;
    logic                  steal_q;
    logic [AGE_WIDTH-1:0]  best_age;
    logic [AGE_WIDTH-1:0]  age [NUM_VOICES];
    logic [NUM_VOICES-1:0] busy_live;
    logic [NUM_VOICES-1:0] sel;
    logic [NUM_VOICES-1:0] capture;
    logic [NUM_VOICES-1:0] busy_next;
    logic [NUM_VOICES-1:0] load_q;
    logic [1:0]            count_next;

    assign busy_live = busy & ~note_done;
    assign handshake = note_valid && note_ready;
    assign capture   = {NUM_VOICES{handshake}} & sel;
    assign busy_next = busy_live | capture;

    // Lowest free voice first; otherwise the oldest, ties to the lowest index.
    always_comb begin
        sel        = '0;
        found_free = 1'b0;
        best_age   = '0;
        for (int unsigned i = 0; i < NUM_VOICES; i++) begin
            if (!found_free && !busy_live[i]) begin
                sel[i]     = 1'b1;
                found_free = 1'b1;
            end
        end
        if (!found_free) begin
            sel[0]   = 1'b1;
            best_age = age[0];
            for (int unsigned i = 1; i < NUM_VOICES; i++) begin
                if (age[i] > best_age) begin
                    sel      = '0;
                    sel[i]   = 1'b1;
                    best_age = age[i];
                end
            end
        end
        all_busy = !found_free;
    end

    always_comb begin
        count_next = '0;
        for (int unsigned i = 0; i < NUM_VOICES; i++) begin
            count_next = count_next + {1'b0, busy_next[i]};
        end
    end

    always_comb begin
        state_next = state;
        note_ready = 1'b0;
        unique case (state)
            IDLE: begin
                note_ready = play && reset;
                if (note_valid && play && reset) begin
                    state_next = LOAD;
                end
            end
            LOAD:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state        <= IDLE;
            load_q       <= '0;
            steal_q      <= 1'b0;
            active_count <= '0;
        end else begin
            state        <= state_next;
            load_q       <= capture;
            steal_q      <= handshake && all_busy;
            active_count <= count_next;
        end
    end

    // Gating by reset lets a reset during LOAD suppress the pending pulse.
    assign load_voice = load_q & {NUM_VOICES{reset}};
    assign steal      = steal_q & reset;

    for (genvar k = 0; k < NUM_VOICES; k++) begin : g_slot
        voice_slot #(
            .AGE_WIDTH(AGE_WIDTH)
        ) u_slot (
            .clk         (clk),
            .reset       (reset),
            .play        (play),
            .beat        (beat),
            .capture     (capture[k]),
            .done        (note_done[k]),
            .note_in     (note_in),
            .duration_in (duration_in),
            .busy        (busy[k]),
            .age         (age[k]),
            .note        (voice_note[NOTE_WIDTH*k +: NOTE_WIDTH]),
            .duration    (voice_duration[NOTE_WIDTH*k +: NOTE_WIDTH])
        );
    end

endmodule

// File: doc/voice_allocator.md
VOICE_ALLOCATOR -- requirements
Module: voice_allocator

Interface
REQ-001 SHALL have parameter NUM_VOICES, default 3, number of note_player voices managed.
REQ-002 SHALL have parameter AGE_WIDTH, default 6, width of per-voice beat-age counter.
REQ-003 SHALL have port clk  input  1  system clock; single clock domain.
REQ-004 SHALL have port reset  input  1  reset, synchronous and active-low.
REQ-005 SHALL have port play  input  1  player running; gates acceptance and aging.
REQ-006 SHALL have port beat  input  1  one-cycle beat pulse from beat_generator.
REQ-007 SHALL have port note_valid  input  1  song_reader offers a note.
REQ-008 SHALL have port note_ready  output  1  allocator accepts the offered note this cycle.
REQ-009 SHALL have port note_in  input  6  note number offered.
REQ-010 SHALL have port duration_in  input  6  duration in beats offered.
REQ-011 SHALL have port note_done  input  NUM_VOICES  per-voice done_with_note pulses.
REQ-012 SHALL have port load_voice  output  NUM_VOICES  one-hot load_new_note pulse to the voices.
REQ-013 SHALL have port voice_note  output  6*NUM_VOICES  registered note per voice, voice k at bits [6k+5:6k].
REQ-014 SHALL have port voice_duration  output  6*NUM_VOICES  registered duration per voice, same packing.
REQ-015 SHALL have port busy  output  NUM_VOICES  voice k holds an unfinished note.
REQ-016 SHALL have port active_count  output  2  population count of busy, for mixer scaling.
REQ-017 SHALL have port steal  output  1  one-cycle pulse when a busy voice was pre-empted.

Function
REQ-018 FSM states: IDLE, LOAD; IDLE->LOAD on note_valid & note_ready; LOAD->IDLE unconditionally.
REQ-019 note_ready SHALL be combinational: 1 iff state==IDLE & play==1 & reset deasserted.
REQ-020 On handshake at edge N, selected voice k SHALL capture note_in/duration_in at edge N; load_voice[k]=1 during cycle N+1 only (latency 1, throughput 1 note per 2 cycles).
REQ-021 Selection: lowest-index voice with busy==0, evaluating busy after same-cycle note_done clears.
REQ-022 If all voices busy: select voice with largest age; tie -> lowest index; steal=1 during cycle N+1.
REQ-023 busy[k] SHALL set on capture for voice k; clear on note_done[k]; capture wins if both hit voice k at the same edge.
REQ-024 age[k] SHALL reset to 0 on capture; increment on beat when play==1 & busy[k]==1; saturate at 2^AGE_WIDTH-1; hold when play==0.
REQ-025 note_done[k] while busy[k]==0 SHALL be ignored.
REQ-026 voice_note/voice_duration for non-selected voices SHALL hold value.
REQ-027 active_count SHALL be registered popcount of busy, updating same edge as busy.
REQ-028 play falling during LOAD SHALL still complete the load pulse.

Reset
REQ-029 While reset==0 at a clk edge: state=IDLE, busy=0, ages=0, voice_note=0, voice_duration=0, load_voice=0, steal=0, active_count=0.
REQ-030 note_ready SHALL be 0 while reset==0; reset mid-LOAD SHALL suppress the pending load_voice pulse.

Structure
REQ-031 NUM_VOICES default, note/duration width (6), and FSM state enum SHALL live in shared package music_pkg.
REQ-032 Per-voice busy/age/note/duration storage SHALL be sub-module voice_slot, instantiated NUM_VOICES times; selection/FSM in top.

Verification
REQ-033 Reset, play=1, note_valid with note 12 dur 4 -> load_voice=001 one cycle later, voice_note[0]=12, busy=001, active_count=1.
REQ-034 Three notes back-to-back -> loads 001,010,100 on alternate cycles; note_ready low each LOAD cycle; active_count=3.
REQ-035 All busy, ages 5/2/5 beats, new note 40 -> voice 0 loaded, steal=1 one cycle, age[0]=0.
REQ-036 All busy, note_done=010 same cycle as handshake -> voice 1 loaded, steal=0.
REQ-037 play=0 with note_valid=1 -> note_ready=0, no load; beats do not advance ages.
REQ-038 reset=0 asserted during LOAD -> no load_voice pulse, all outputs 0 next cycle.
